// File: rtl/cor_sel_arb_if.sv
// Bundle of the requester handshake, shared correction-select datapath and
// response signals of cor_sel_arb. The slave modport is the arbiter side.
interface cor_sel_arb_if #(
    parameter int DATA_WIDTH = 18
);
    logic                        hold;
    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [1:0][DATA_WIDTH-1:0]  req_A;
    logic [1:0][1:0]             req_sign;
    logic                        cs_valid;
    logic [DATA_WIDTH-1:0]       cs_A;
    logic [1:0]                  cs_sign;
    logic [DATA_WIDTH-1:0]       cs_A_out;
    logic [DATA_WIDTH-1:0]       cs_result;
    logic [1:0]                  rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_A;
    logic [DATA_WIDTH-1:0]       rsp_result;
    logic                        rsp_err;
    logic [7:0]                  err_cnt;

    modport slave (
        input  hold, req_valid, req_A, req_sign, cs_A_out, cs_result,
        output req_ready, cs_valid, cs_A, cs_sign,
        output rsp_valid, rsp_A, rsp_result, rsp_err, err_cnt
    );

    modport master (
        output hold, req_valid, req_A, req_sign, cs_A_out, cs_result,
        input  req_ready, cs_valid, cs_A, cs_sign,
        input  rsp_valid, rsp_A, rsp_result, rsp_err, err_cnt
    );
endinterface

// File: rtl/cor_sel_arb.sv
// Two-requester round-robin arbiter in front of a fixed-latency correction-select
// datapath; a non-stalling tag pipe routes each datapath result back to its owner.
module cor_sel_arb #(
    parameter int DATA_WIDTH = 18,
    parameter int LATENCY    = 2
) (
    input logic          clk,
    input logic          rst_n,
    cor_sel_arb_if.slave bus
);

    typedef struct packed {
        logic vld;
        logic id;
        logic err;
    } tag_t;

    logic                  ptr_q;
    logic                  cs_valid_q;
    logic [DATA_WIDTH-1:0] cs_A_q;
    logic [1:0]            cs_sign_q;
    logic [7:0]            err_cnt_q;
    tag_t [LATENCY:0]      tag_q;
    logic [1:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_A_q;
    logic [DATA_WIDTH-1:0] rsp_result_q;
    logic                  rsp_err_q;

    logic [1:0]            ready;
    logic                  accept;
    logic                  win;
    logic                  illegal;
    logic [1:0]            cs_sign_d;
    logic [7:0]            err_cnt_d;
    tag_t                  tag_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Pointer only matters under contention; a lone requester always wins.
    always_comb begin
        ready = 2'b00;
        if (!bus.hold) begin
            if (&bus.req_valid) ready = ptr_q ? 2'b10 : 2'b01;
            else                ready = bus.req_valid;
        end
    end

    assign accept    = |(bus.req_valid & ready);
    assign win       = ready[1];
    assign illegal   = (bus.req_sign[win] == 2'd3);
    assign cs_sign_d = illegal ? 2'b00 : bus.req_sign[win];
    assign err_cnt_d = (accept && illegal) ? sat_inc(err_cnt_q) : err_cnt_q;
    assign tag_d     = '{vld: accept, id: win, err: accept & illegal};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= 1'b0;
            cs_valid_q   <= 1'b0;
            cs_A_q       <= '0;
            cs_sign_q    <= 2'b00;
            err_cnt_q    <= 8'd0;
            tag_q        <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_A_q      <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            cs_valid_q <= accept;
            if (accept) begin
                ptr_q     <= ~win;
                cs_A_q    <= bus.req_A[win];
                cs_sign_q <= cs_sign_d;
            end
            err_cnt_q <= err_cnt_d;

            // Tag stage LATENCY lines up with the datapath result of the same transfer.
            tag_q[0] <= tag_d;
            for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];

            rsp_valid_q <= tag_q[LATENCY].vld ? (tag_q[LATENCY].id ? 2'b10 : 2'b01) : 2'b00;
            rsp_err_q   <= tag_q[LATENCY].vld & tag_q[LATENCY].err;
            if (tag_q[LATENCY].vld) begin
                rsp_A_q      <= bus.cs_A_out;
                rsp_result_q <= bus.cs_result;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.cs_valid   = cs_valid_q;
    assign bus.cs_A       = cs_A_q;
    assign bus.cs_sign    = cs_sign_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_A      = rsp_A_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cor_sel_arb.sv
// Bench for cor_sel_arb: directed and random requests against a transaction-level
// model (grant choice, expected-response queue keyed by due cycle, saturating count).
module tb_cor_sel_arb;

    localparam int DW  = 18;
    localparam int LAT = 2;
    localparam logic [DW-1:0] CORR = 18'h01555;

    logic clk = 1'b0;
    logic rst_n;

    cor_sel_arb_if #(.DATA_WIDTH(DW)) bus ();

    cor_sel_arb #(.DATA_WIDTH(DW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] corr(input logic [DW-1:0] a, input logic [1:0] s);
        case (s)
            2'd1:    return a + CORR;
            2'd2:    return a - CORR;
            default: return a;
        endcase
    endfunction

    // Environment: the shared datapath, LAT register stages deep.
    logic [DW-1:0] dpA [LAT];
    logic [DW-1:0] dpR [LAT];
    always_ff @(posedge clk) begin
        dpA[0] <= bus.cs_A;
        dpR[0] <= corr(bus.cs_A, bus.cs_sign);
        for (int i = 1; i < LAT; i++) begin
            dpA[i] <= dpA[i-1];
            dpR[i] <= dpR[i-1];
        end
    end
    assign bus.cs_A_out  = dpA[LAT-1];
    assign bus.cs_result = dpR[LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [DW-1:0] a;
        logic [DW-1:0] r;
        logic        err;
    } exp_t;

    exp_t          q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            ptr_m;
    logic          csv_m;
    logic [DW-1:0] csA_m;
    logic [1:0]    css_m;
    int            err_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr_m = 0;
        csv_m = 1'b0;
        csA_m = '0;
        css_m = 2'b00;
        err_m = 0;
    endtask

    task automatic chk_all_zero();
        chk("rst_cs_valid", {31'd0, bus.cs_valid}, 32'd0);
        chk("rst_cs_A", {14'd0, bus.cs_A}, 32'd0);
        chk("rst_cs_sign", {30'd0, bus.cs_sign}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_A", {14'd0, bus.rsp_A}, 32'd0);
        chk("rst_rsp_result", {14'd0, bus.rsp_result}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    endtask

    // One clock: predict the grant, take the edge, then check registered outputs.
    task automatic cycle();
        int         w;
        logic [1:0] se;
        exp_t       e;
        #1;
        w = -1;
        if (!bus.hold) begin
            if (bus.req_valid == 2'b11) w = ptr_m;
            else if (bus.req_valid[0])  w = 0;
            else if (bus.req_valid[1])  w = 1;
        end
        chk("req_ready", {30'd0, bus.req_ready}, (w < 0) ? 32'd0 : (32'd1 << w));
        @(posedge clk);
        cyc++;
        if (w >= 0) begin
            se    = (bus.req_sign[w] == 2'd3) ? 2'd0 : bus.req_sign[w];
            e.due = cyc + LAT + 1;
            e.id  = w;
            e.a   = bus.req_A[w];
            e.r   = corr(bus.req_A[w], se);
            e.err = (bus.req_sign[w] == 2'd3);
            q.push_back(e);
            csv_m = 1'b1;
            csA_m = bus.req_A[w];
            css_m = se;
            if (e.err && err_m < 255) err_m++;
            ptr_m = 1 - w;
        end else begin
            csv_m = 1'b0;
        end
        #1;
        chk("cs_valid", {31'd0, bus.cs_valid}, {31'd0, csv_m});
        chk("cs_A", {14'd0, bus.cs_A}, {14'd0, csA_m});
        chk("cs_sign", {30'd0, bus.cs_sign}, {30'd0, css_m});
        chk("err_cnt", {24'd0, bus.err_cnt}, err_m);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", {30'd0, bus.rsp_valid}, 32'd1 << q[0].id);
            chk("rsp_A", {14'd0, bus.rsp_A}, {14'd0, q[0].a});
            chk("rsp_result", {14'd0, bus.rsp_result}, {14'd0, q[0].r});
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, q[0].err});
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", {30'd0, bus.rsp_valid}, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input logic h,
                         input logic [DW-1:0] a0, input logic [1:0] s0,
                         input logic [DW-1:0] a1, input logic [1:0] s1);
        bus.req_valid   = v;
        bus.hold        = h;
        bus.req_A[0]    = a0;
        bus.req_sign[0] = s0;
        bus.req_A[1]    = a1;
        bus.req_sign[1] = s1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 2'b00;
        bus.hold      = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.hold      = 1'b0;
        model_reset();
        #1;
        chk_all_zero();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 1'b0, '0, 2'd0, '0, 2'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_all_zero();
        rst_n = 1'b1;

        // Single request from requester 0.
        drive(2'b01, 1'b0, 18'h12345, 2'd1, 18'h3FFFF, 2'd2);
        cycle();
        idle(5);

        // Contention straight from reset: grants alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b0, DW'($urandom), 2'($urandom_range(0, 2)),
                               DW'($urandom), 2'($urandom_range(0, 2)));
            cycle();
        end
        idle(5);

        // Illegal sign code from requester 1.
        drive(2'b10, 1'b0, 18'h00001, 2'd1, 18'h26543, 2'd3);
        cycle();
        idle(5);
        chk("err_cnt_one", {24'd0, bus.err_cnt}, 32'd1);

        // Accept, then hold with both requesters valid; the accepted one still responds.
        drive(2'b01, 1'b0, 18'h0ABCD, 2'd2, 18'h00000, 2'd0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b1, DW'($urandom), 2'd1, DW'($urandom), 2'd2);
            cycle();
        end
        idle(4);

        // Sign code 2 from requester 1.
        drive(2'b10, 1'b0, 18'h00000, 2'd0, 18'h20F0F, 2'd2);
        cycle();
        idle(5);

        // Random traffic with occasional hold.
        for (int i = 0; i < 200; i++) begin
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  DW'($urandom), 2'($urandom_range(0, 3)),
                  DW'($urandom), 2'($urandom_range(0, 3)));
            cycle();
        end
        idle(5);

        // 300 illegal requests saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(1, 3)), 1'b0, DW'($urandom), 2'd3, DW'($urandom), 2'd3);
            cycle();
        end
        idle(5);
        chk("err_cnt_sat", {24'd0, bus.err_cnt}, 32'd255);

        // Reset between the two edges after an accept; nothing may respond afterwards.
        drive(2'b10, 1'b0, 18'h00000, 2'd0, 18'h15A5A, 2'd1);
        cycle();
        idle(1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero();
        #2;
        rst_n = 1'b1;
        idle(6);
        drive(2'b11, 1'b0, 18'h01111, 2'd1, 18'h02222, 2'd2);
        cycle();
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
